// File: rtl/hls_kernel_driver_if.sv
// Bus bundle between a host/stream source, the kernel driver and one kernel instance.
// Optional completion handshake signals exist only when KDRV_DONE_PORT_EN is defined.
interface hls_kernel_driver_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] res_data;
  logic [CNT_W-1:0]  res_cycles;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] k_a;
  logic [DATA_W-1:0] k_b;
  logic              k_rst_n;
  logic [DATA_W-1:0] k_ret;
  logic              busy;
`ifdef KDRV_DONE_PORT_EN
  logic              k_done;
  logic              res_timeout;
`endif

  // Driver side.
  modport master (
    input  in_a, in_b, in_valid, res_ready, k_ret,
    output in_ready, res_data, res_cycles, res_valid, k_a, k_b, k_rst_n, busy
`ifdef KDRV_DONE_PORT_EN
    , input  k_done
    , output res_timeout
`endif
  );

  // Source, consumer and kernel side.
  modport slave (
    output in_a, in_b, in_valid, res_ready, k_ret,
    input  in_ready, res_data, res_cycles, res_valid, k_a, k_b, k_rst_n, busy
`ifdef KDRV_DONE_PORT_EN
    , output k_done
    , input  res_timeout
`endif
  );
endinterface

// File: rtl/hls_kernel_driver.sv
// Caller-side initiator for single-shot HLS kernels: latch operands, pulse the kernel
// reset, wait a fixed completion budget, capture return_val and hand it out.
// Optional macro KDRV_DONE_PORT_EN adds an early-completion input (k_done) and a
// res_timeout flag.
module hls_kernel_driver #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned LAT_CYCLES = 64,
  parameter int unsigned CNT_W      = 16
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  hls_kernel_driver_if.master bus
);

  if (RST_CYCLES < 1 || LAT_CYCLES < 1 || CNT_W < 1 || CNT_W > 32 ||
      64'(RST_CYCLES) >= (64'd1 << CNT_W) ||
      64'(LAT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_params
    $error("hls_kernel_driver: RST_CYCLES/LAT_CYCLES must be in [1, 2^CNT_W)");
  end

  localparam logic [CNT_W-1:0] RstLast = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LatLast = CNT_W'(LAT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StKrst, StRun, StCapt, StResp} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] k_a_q, k_a_d;
  logic [DATA_W-1:0] k_b_q, k_b_d;
  logic              k_rst_n_q, k_rst_n_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [CNT_W-1:0]  res_cycles_q, res_cycles_d;
  logic              res_valid_q, res_valid_d;
`ifdef KDRV_DONE_PORT_EN
  logic              res_timeout_q, res_timeout_d;
`endif

  // State and datapath registers; async reset also yanks the kernel back into reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      k_a_q         <= '0;
      k_b_q         <= '0;
      k_rst_n_q     <= 1'b0;
      res_data_q    <= '0;
      res_cycles_q  <= '0;
      res_valid_q   <= 1'b0;
`ifdef KDRV_DONE_PORT_EN
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      k_a_q         <= k_a_d;
      k_b_q         <= k_b_d;
      k_rst_n_q     <= k_rst_n_d;
      res_data_q    <= res_data_d;
      res_cycles_q  <= res_cycles_d;
      res_valid_q   <= res_valid_d;
`ifdef KDRV_DONE_PORT_EN
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

  // Next-state logic for the call sequence IDLE -> KRST -> RUN -> CAPT -> RESP.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    k_a_d         = k_a_q;
    k_b_d         = k_b_q;
    k_rst_n_d     = k_rst_n_q;
    res_data_d    = res_data_q;
    res_cycles_d  = res_cycles_q;
    res_valid_d   = res_valid_q;
`ifdef KDRV_DONE_PORT_EN
    res_timeout_d = res_timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        // in_ready is high in this state, so in_valid alone completes the handshake.
        if (bus.in_valid) begin
          k_a_d   = bus.in_a;
          k_b_d   = bus.in_b;
          cnt_d   = '0;
          state_d = StKrst;
        end
      end
      StKrst: begin
        if (cnt_q == RstLast) begin
          cnt_d     = '0;
          k_rst_n_d = 1'b1;
          state_d   = StRun;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRun: begin
        // Counter holds on exit so CAPT reports the number of RUN cycles as cnt_q + 1.
`ifdef KDRV_DONE_PORT_EN
        if (bus.k_done) begin
          res_timeout_d = 1'b0;
          state_d       = StCapt;
        end else if (cnt_q == LatLast) begin
          res_timeout_d = 1'b1;
          state_d       = StCapt;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        if (cnt_q == LatLast) begin
          state_d = StCapt;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      StCapt: begin
        res_data_d   = bus.k_ret;
        res_cycles_d = cnt_q + CNT_W'(1);
        res_valid_d  = 1'b1;
        k_rst_n_d    = 1'b0;
        state_d      = StResp;
      end
      StResp: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.k_a         = k_a_q;
  assign bus.k_b         = k_b_q;
  assign bus.k_rst_n     = k_rst_n_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_cycles  = res_cycles_q;
  assign bus.res_valid   = res_valid_q;
`ifdef KDRV_DONE_PORT_EN
  assign bus.res_timeout = res_timeout_q;
`endif

endmodule
